// File: rtl/nonce_search_ctrl.sv
// Nonce search sequencer in front of a SHA-256 core: launches one hash per nonce,
// compares each digest against a target and stops on a hit, range end or abort.
module nonce_search_ctrl #(
    parameter int PREFIX_W = 408,
    parameter int NONCE_W  = 32
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [PREFIX_W-1:0]         header_prefix,
    input  logic [255:0]                target,
    input  logic [NONCE_W-1:0]          nonce_start,
    input  logic [NONCE_W-1:0]          nonce_end,
    output logic [PREFIX_W+NONCE_W-1:0] sha_msg,
    output logic                        sha_begin,
    input  logic                        sha_done,
    input  logic [255:0]                sha_hash,
    output logic                        busy,
    output logic                        found,
    output logic                        exhausted,
    output logic [NONCE_W-1:0]          result_nonce,
    output logic [255:0]                result_hash,
    output logic [NONCE_W:0]            hash_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        DRAIN = 3'd5
    } state_t;

    state_t state;
    state_t next_state;

    logic [PREFIX_W-1:0] prefix_q;
    logic [255:0]        target_q;
    logic [255:0]        hash_q;
    logic [NONCE_W-1:0]  nonce_q;
    logic [NONCE_W-1:0]  nonce_end_q;

    logic start_ok;
    logic hit;
    logic last_nonce;
    logic begin_d;
    logic busy_d;

    assign start_ok   = start && !abort && (state == IDLE || state == DONE);
    assign hit        = (hash_q <= target_q);
    assign last_nonce = (nonce_q == nonce_end_q);

    // Both halves are registers, so the message is held steady while a hash runs.
    assign sha_msg = {prefix_q, nonce_q};

    always_comb begin
        next_state = state;
        begin_d    = 1'b0;
        busy_d     = 1'b0;
        if (abort) begin
            // A launched hash cannot be recalled; wait out its sha_done unless it lands now.
            case (state)
                ISSUE:   next_state = DRAIN;
                WAIT:    next_state = sha_done ? IDLE : DRAIN;
                DRAIN:   next_state = sha_done ? IDLE : DRAIN;
                default: next_state = IDLE;
            endcase
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        next_state = ISSUE;
                    end
                end
                ISSUE: next_state = WAIT;
                WAIT: begin
                    if (sha_done) begin
                        next_state = CHECK;
                    end
                end
                CHECK: next_state = (hit || last_nonce) ? DONE : ISSUE;
                DRAIN: begin
                    if (sha_done) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
        begin_d = (next_state == ISSUE);
        busy_d  = (next_state == ISSUE) || (next_state == WAIT) ||
                  (next_state == CHECK) || (next_state == DRAIN);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            sha_begin <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            sha_begin <= begin_d;
            busy      <= busy_d;
        end
    end

    // Job context, digest capture and result bookkeeping.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prefix_q     <= '0;
            target_q     <= '0;
            hash_q       <= '0;
            nonce_q      <= '0;
            nonce_end_q  <= '0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            result_nonce <= '0;
            result_hash  <= '0;
            hash_count   <= '0;
        end else if (abort) begin
            found      <= 1'b0;
            exhausted  <= 1'b0;
            hash_count <= '0;
        end else if (start_ok) begin
            prefix_q    <= header_prefix;
            target_q    <= target;
            nonce_q     <= nonce_start;
            nonce_end_q <= nonce_end;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            hash_count  <= '0;
        end else if (state == WAIT && sha_done) begin
            hash_q     <= sha_hash;
            hash_count <= hash_count + 1'b1;
        end else if (state == CHECK) begin
            // A hit on the final nonce reports found, not exhausted.
            if (hit) begin
                found        <= 1'b1;
                result_nonce <= nonce_q;
                result_hash  <= hash_q;
            end else if (last_nonce) begin
                exhausted <= 1'b1;
            end else begin
                nonce_q <= nonce_q + 1'b1;
            end
        end
    end

endmodule

// File: doc/nonce_search_ctrl.md
# nonce_search_ctrl

Mining control stage directly upstream of the SHA-256 computational block. Per job it assembles the 440-bit block message from a 408-bit header prefix and a 32-bit nonce and launches one hash. It compares each returned 256-bit digest against a target and steps the nonce through a programmed range. It stops on the first hit, on range exhaustion, or on abort.

## Interface

**Parameters**
- PREFIX_W, 408: header prefix width.
- NONCE_W, 32: nonce width; message width = PREFIX_W + NONCE_W.

**Ports**
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle job start; accepted only in IDLE or DONE.
- abort  in  1  one-cycle job cancel; accepted in any state.
- header_prefix  in  PREFIX_W  header bits; latched on accepted start.
- target  in  256  unsigned threshold; latched on accepted start.
- nonce_start  in  NONCE_W  first nonce; latched on accepted start.
- nonce_end  in  NONCE_W  last nonce (inclusive); latched on accepted start.
- sha_msg  out  PREFIX_W+NONCE_W  {prefix_q, nonce_q}, registered.
- sha_begin  out  1  one-cycle hash launch.
- sha_done  in  1  one-cycle hash-complete pulse.
- sha_hash  in  256  digest; valid in the sha_done cycle only.
- busy  out  1  high in ISSUE, WAIT, CHECK and DRAIN.
- found  out  1  level; a hit was found.
- exhausted  out  1  level; the range ended with no hit.
- result_nonce  out  NONCE_W  nonce of the hit.
- result_hash  out  256  digest of the hit.
- hash_count  out  NONCE_W+1  hashes checked in the current job.

## Operation

**States:** IDLE, ISSUE, WAIT, CHECK, DONE, DRAIN.

**Reset:** state = IDLE. The following reset to 0: sha_begin, busy, found, exhausted, result_nonce, result_hash, hash_count, sha_msg, and all internal registers.

**Transitions**
- IDLE/DONE + start → ISSUE.
  - Latch prefix, target, nonce_start and nonce_end.
  - Clear found, exhausted and hash_count.
  - result_nonce and result_hash keep their old values until the next hit.
- ISSUE → WAIT.
  - sha_begin = 1 for exactly this cycle.
  - sha_msg is stable from ISSUE through the end of WAIT.
- WAIT + sha_done → CHECK.
  - Register sha_hash into hash_q.
  - hash_count increments by 1.
  - sha_done in any other state is ignored, except in DRAIN.
- CHECK compares hash_q against the latched target; the hash is taken as the unsigned 256-bit value {h0..h7}, h0 is the MSB, and a hit is hash_q ≤ target.
  - Hit → DONE: found = 1, result_nonce = nonce_q, result_hash = hash_q.
  - No hit and nonce_q == nonce_end → DONE: exhausted = 1.
  - Otherwise → ISSUE with nonce_q = nonce_q + 1 mod 2^NONCE_W.
  - The hit test takes priority over the end-of-range test.
- DONE: found or exhausted is held until the next accepted start or an abort.

**Nonce range**
- The nonce wraps past all-ones to 0.
- If nonce_end < nonce_start, the search wraps through 0.
- nonce_end == nonce_start − 1 (mod 2^NONCE_W) covers the full 2^NONCE_W range; hash_count reaches 2^NONCE_W without overflow.

**Abort**
- abort in WAIT or ISSUE → DRAIN. A hash is in flight from ISSUE onward, and the downstream block cannot be cancelled.
- DRAIN + sha_done → IDLE; that digest is discarded.
- abort in IDLE, CHECK or DONE → IDLE.
- All aborts clear found, exhausted and hash_count.
- abort and start in the same cycle: abort wins and start is dropped.
- start in any busy state (including DRAIN) is ignored.

## Timing

- Accepted start at cycle 0 → sha_begin at cycle 1.
- sha_done at cycle t → CHECK at t+1 → one of:
  - next sha_begin at t+2, or
  - found/exhausted visible at t+2.
- Per-nonce cost = SHA latency + 3 cycles. The three cycles are ISSUE, CHECK, and the sha_done cycle in WAIT.
- All outputs are registered; there are no combinational input-to-output paths.
- Async reset mid-job forces IDLE immediately. The downstream block shares n_rst, so no drain is needed after reset.

## Test plan

Bench uses a stub SHA model with a fixed 70-cycle latency and a scripted digest queue.

- **Reset:** assert n_rst low mid-WAIT → all outputs 0 and state IDLE on the same edge; sha_begin stays 0 until the next start.
- **Hit on third nonce:**
  - Stimulus: nonce_start = 0x10, nonce_end = 0x20, target = 0x0000FFFF…FF; stub returns 0xFFFF…, 0x0001_0000…0, then 0x0000_FFFF…FF (equal to target).
  - Required: found = 1, result_nonce = 0x12, hash_count = 3; exactly 3 sha_begin pulses, each with sha_msg[31:0] = nonce.
- **Exhaustion with wrap:**
  - Stimulus: nonce_start = 0xFFFFFFFE, nonce_end = 0x00000001, all digests above target.
  - Required: 4 hashes in the order FFFFFFFE, FFFFFFFF, 0, 1; then exhausted = 1, found = 0, hash_count = 4.
- **Abort in flight:** abort 10 cycles after sha_begin → busy stays 1 until the stub's sha_done, then IDLE. A start during DRAIN is ignored; a start after IDLE launches nonce_start cleanly.
- **Start/abort collision:** start and abort in the same cycle while in DONE → IDLE, no sha_begin, found cleared.
- **Latency:** sha_done at cycle t → next sha_begin at exactly t+2; start at cycle 0 → sha_begin at cycle 1; sha_msg unchanged throughout WAIT.
